// File: rtl/key_search_ctrl.sv
// Brute-force key-search sequencer: walks [key_start, key_end] in batches of LANES keys.
// Optional search statistics (tested-key counter) enabled by defining KSC_STATS_EN.
module key_search_ctrl #(
    parameter int KEY_W = 56,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_start,
    input  logic [KEY_W-1:0] key_end,
    input  logic             eng_ready,
    input  logic             eng_valid,
    input  logic [LANES-1:0] eng_match,
    output logic [KEY_W-1:0] key_base,
    output logic [LANES-1:0] lane_en,
    output logic             launch,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key
`ifdef KSC_STATS_EN
    ,
    output logic [KEY_W:0]   tested
`endif
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_FOUND   = 3'd3,
        S_EXHAUST = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_base_q, key_base_d;
    logic [KEY_W-1:0] key_end_q, key_end_d;
    logic [KEY_W-1:0] found_key_q, found_key_d;
    logic [LANES-1:0] lane_en_q, lane_en_d;
    logic [LANES-1:0] hit_s;
    logic [KEY_W:0]   next_base_s;
    logic             launch_s;

    // Compares run one bit wider so a batch ending at the all-ones key never wraps.
    function automatic logic [LANES-1:0] calc_lanes(input logic [KEY_W-1:0] base,
                                                    input logic [KEY_W-1:0] last);
        logic [LANES-1:0] en;
        logic [KEY_W:0]   k;
        en = '0;
        for (int i = 0; i < LANES; i++) begin
            k     = {1'b0, base} + (KEY_W+1)'(i);
            en[i] = (k <= {1'b0, last});
        end
        return en;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [LANES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Next-state and datapath update for the search sequencer.
    always_comb begin
        state_d     = state_q;
        key_base_d  = key_base_q;
        key_end_d   = key_end_q;
        found_key_d = found_key_q;
        lane_en_d   = lane_en_q;
        launch_s    = 1'b0;
        hit_s       = eng_match & lane_en_q;
        next_base_s = {1'b0, key_base_q} + (KEY_W+1)'(LANES);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_base_d  = key_start;
                    key_end_d   = key_end;
                    lane_en_d   = calc_lanes(key_start, key_end);
                    found_key_d = '0;
                    if (key_start > key_end) begin
                        state_d = S_EXHAUST;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (eng_ready) begin
                    launch_s = 1'b1;
                    state_d  = S_WAIT;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (eng_valid) begin
                    if (|hit_s) begin
                        found_key_d = key_base_q + KEY_W'(lowest_idx(hit_s));
                        state_d     = S_FOUND;
                    end else if (next_base_s > {1'b0, key_end_q}) begin
                        state_d = S_EXHAUST;
                    end else begin
                        key_base_d = next_base_s[KEY_W-1:0];
                        lane_en_d  = calc_lanes(next_base_s[KEY_W-1:0], key_end_q);
                        state_d    = S_LAUNCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FOUND, S_EXHAUST: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_base_q  <= '0;
            key_end_q   <= '0;
            found_key_q <= '0;
            lane_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            key_base_q  <= key_base_d;
            key_end_q   <= key_end_d;
            found_key_q <= found_key_d;
            lane_en_q   <= lane_en_d;
        end
    end

    assign key_base  = key_base_q;
    assign lane_en   = lane_en_q;
    assign found_key = found_key_q;
    assign launch    = launch_s;
    assign busy      = (state_q != S_IDLE);
    assign found     = (state_q == S_FOUND);
    assign exhausted = (state_q == S_EXHAUST);

`ifdef KSC_STATS_EN
    logic [KEY_W:0] tested_q, tested_d;

    function automatic int popcount(input logic [LANES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Count keys tried: every lane carrying a real key in a completed batch.
    always_comb begin
        tested_d = tested_q;
        if (state_q == S_IDLE && start) begin
            tested_d = '0;
        end else if (state_q == S_WAIT && eng_valid && !abort) begin
            tested_d = tested_q + (KEY_W+1)'(popcount(lane_en_q));
        end else begin
            tested_d = tested_q;
        end
    end

    // Tested-key counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tested_q <= '0;
        end else begin
            tested_q <= tested_d;
        end
    end

    assign tested = tested_q;
`endif

endmodule
